// File: rtl/syndrome_gen_if.sv
// Symbol-in / syndrome-out stream bundle for the syndrome generator.
// master drives symbols and observes syndromes; slave is the generator side.
interface syndrome_gen_if;
    localparam int unsigned SYM_W = 4;

    logic             in_valid;
    logic [SYM_W-1:0] in_symbol;
    logic             out_valid;
    logic [SYM_W-1:0] out_syndrome;
    logic             out_clean;

    modport master (
        output in_valid,
        output in_symbol,
        input  out_valid,
        input  out_syndrome,
        input  out_clean
    );

    modport slave (
        input  in_valid,
        input  in_symbol,
        output out_valid,
        output out_syndrome,
        output out_clean
    );
endinterface

// File: rtl/syndrome_gen.sv
// GF(16) syndrome generator: Horner-evaluates S1..S6 of a 15-symbol codeword and
// streams them out in exponent form, double-buffered against the next frame.
module syndrome_gen (
    input  logic          clk,
    input  logic          rst,
    syndrome_gen_if.slave bus
);
    localparam int unsigned N_SYM = 15;
    localparam int unsigned N_SYN = 6;
    localparam int unsigned SYM_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] acc_q [N_SYN];
    logic [SYM_W-1:0] acc_d [N_SYN];
    logic [SYM_W-1:0] sr_q  [N_SYN];
    logic [SYM_W-1:0] sr_d  [N_SYN];
    logic             clean_q, clean_d;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_syndrome_q, out_syndrome_d;
    logic             out_clean_q, out_clean_d;
    logic             frame_done_c;
    logic             all_zero_c;

    // Multiply by alpha modulo x^4+x+1: shift left, fold x^4 back as x+1.
    function automatic logic [SYM_W-1:0] mul_alpha(input logic [SYM_W-1:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    // Constant multiply by alpha^p; p is fixed per accumulator so this folds to XORs.
    function automatic logic [SYM_W-1:0] mul_alpha_pow(input logic [SYM_W-1:0] a,
                                                       input int unsigned    p);
        logic [SYM_W-1:0] r;
        r = a;
        for (int unsigned k = 0; k < N_SYN; k++) begin
            if (k < p) r = mul_alpha(r);
        end
        return r;
    endfunction

    // Vector-to-exponent log ROM; the zero element maps to 4'hF.
    function automatic logic [SYM_W-1:0] log_rom(input logic [SYM_W-1:0] v);
        logic [SYM_W-1:0] e;
        case (v)
            4'h1:    e = 4'd0;
            4'h2:    e = 4'd1;
            4'h3:    e = 4'd4;
            4'h4:    e = 4'd2;
            4'h5:    e = 4'd8;
            4'h6:    e = 4'd5;
            4'h7:    e = 4'd10;
            4'h8:    e = 4'd3;
            4'h9:    e = 4'd14;
            4'hA:    e = 4'd9;
            4'hB:    e = 4'd7;
            4'hC:    e = 4'd6;
            4'hD:    e = 4'd13;
            4'hE:    e = 4'd11;
            4'hF:    e = 4'd12;
            default: e = 4'hF;
        endcase
        return e;
    endfunction

    // Horner accumulation and symbol counting; cnt==0 restarts the accumulators.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        frame_done_c = 1'b0;
        all_zero_c   = 1'b1;
        if (bus.in_valid) begin
            for (int unsigned j = 0; j < N_SYN; j++) begin
                acc_d[j] = ((cnt_q == '0) ? SYM_W'(0) : mul_alpha_pow(acc_q[j], j + 1))
                           ^ bus.in_symbol;
            end
            if (cnt_q == CNT_W'(N_SYM - 1)) begin
                frame_done_c = 1'b1;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        for (int unsigned j = 0; j < N_SYN; j++) begin
            if (acc_d[j] != '0) all_zero_c = 1'b0;
        end
    end

    // Output FSM plus handoff of finished syndromes into the send buffer.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        sr_d           = sr_q;
        clean_d        = clean_q;
        out_valid_d    = 1'b0;
        out_syndrome_d = '0;
        out_clean_d    = 1'b0;

        if (frame_done_c) begin
            for (int unsigned j = 0; j < N_SYN; j++) sr_d[j] = log_rom(acc_d[j]);
            clean_d = all_zero_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_done_c) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                out_valid_d    = 1'b1;
                out_syndrome_d = sr_q[idx_q];
                out_clean_d    = (idx_q == '0) && clean_q;
                if (idx_q == IDX_W'(N_SYN - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            clean_q        <= 1'b0;
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            out_valid_q    <= 1'b0;
            out_syndrome_q <= '0;
            out_clean_q    <= 1'b0;
            for (int unsigned j = 0; j < N_SYN; j++) begin
                acc_q[j] <= '0;
                sr_q[j]  <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            clean_q        <= clean_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            out_valid_q    <= out_valid_d;
            out_syndrome_q <= out_syndrome_d;
            out_clean_q    <= out_clean_d;
            for (int unsigned j = 0; j < N_SYN; j++) begin
                acc_q[j] <= acc_d[j];
                sr_q[j]  <= sr_d[j];
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_syndrome = out_syndrome_q;
    assign bus.out_clean    = out_clean_q;
endmodule

// File: tb/tb_syndrome_gen.sv
// Bench for syndrome_gen: reference evaluates r(alpha^j) directly from the
// collected codeword using exp/log tables, and schedules the expected output beats.
module tb_syndrome_gen;
    logic clk;
    logic rst;

    syndrome_gen_if bus ();

    syndrome_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int syn;
        int clean;
    } beat_t;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    exp_t [15];
    int    log_t [16];
    int    frame [$];
    beat_t exp_q [$];
    int    obs [6];
    int    obs_n      = 0;
    int    obs_clean  = 0;
    logic  prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 15];
    endfunction

    // Reference: collect the frame, then evaluate each syndrome as a polynomial sum.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            frame.delete();
            exp_q.delete();
        end else if (bus.in_valid) begin
            frame.push_back(int'(bus.in_symbol));
            if (frame.size() == 15) begin
                int s [6];
                int all_zero;
                all_zero = 1;
                for (int j = 1; j <= 6; j++) begin
                    s[j-1] = 0;
                    for (int k = 0; k < 15; k++)
                        s[j-1] ^= gf_mul(frame[k], exp_t[((14 - k) * j) % 15]);
                    if (s[j-1] != 0) all_zero = 0;
                end
                for (int j = 0; j < 6; j++) begin
                    beat_t b;
                    b.due   = cyc + 1 + j;
                    b.syn   = (s[j] == 0) ? 15 : log_t[s[j]];
                    b.clean = (j == 0) ? all_zero : 0;
                    exp_q.push_back(b);
                end
                frame.delete();
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            beat_t b;
            b = exp_q.pop_front();
            chk("syndrome", 32'(bus.out_syndrome), 32'(b.syn));
            chk("clean", 32'(bus.out_clean), 32'(b.clean));
        end else begin
            chk("idle_syndrome", 32'(bus.out_syndrome), 32'd0);
            chk("idle_clean", 32'(bus.out_clean), 32'd0);
        end
        if (bus.out_valid === 1'b1) begin
            if (!prev_valid) begin
                obs_n     = 0;
                obs_clean = int'(bus.out_clean);
            end
            if (obs_n < 6) obs[obs_n] = int'(bus.out_syndrome);
            obs_n++;
        end
        prev_valid = (bus.out_valid === 1'b1);
    end

    task automatic drive_sym(input logic [3:0] s);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_symbol = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.in_symbol = 4'($urandom);
        end
    endtask

    // pos = coefficient index of the single error (-1 for all-zero); optional gap.
    task automatic send_err_frame(input int pos, input logic [3:0] v,
                                  input int gap_at, input int gap_len);
        for (int k = 0; k < 15; k++) begin
            drive_sym((k == 14 - pos) ? v : 4'h0);
            if (k + 1 == gap_at) idle(gap_len);
        end
    endtask

    task automatic send_random_frame();
        int mode;
        mode = $urandom_range(0, 2);
        for (int k = 0; k < 15; k++) begin
            logic [3:0] s;
            if (mode == 0)      s = 4'($urandom);
            else if (mode == 1) s = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            else                s = 4'h0;
            drive_sym(s);
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic check_burst(input string tag, input int e [6], input int ec);
        chk({tag, "_len"}, 32'(obs_n), 32'd6);
        for (int i = 0; i < 6; i++) chk({tag, "_S"}, 32'(obs[i]), 32'(e[i]));
        chk({tag, "_clean"}, 32'(obs_clean), 32'(ec));
    endtask

    initial begin
        int e;
        e = 1;
        for (int i = 0; i < 15; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if ((e & 16) != 0) e ^= 'h13;
        end
        log_t[0] = 15;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_symbol = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        send_err_frame(-1, 4'h0, 0, 0);
        idle(8);
        check_burst("all_zero", '{15, 15, 15, 15, 15, 15}, 1);

        send_err_frame(0, 4'h1, 0, 0);
        idle(8);
        check_burst("err_r0", '{0, 0, 0, 0, 0, 0}, 0);

        send_err_frame(1, 4'h1, 0, 0);
        idle(8);
        check_burst("err_r1", '{1, 2, 3, 4, 5, 6}, 0);

        send_err_frame(14, 4'h1, 0, 0);
        idle(8);
        check_burst("err_r14", '{14, 13, 12, 11, 10, 9}, 0);

        send_err_frame(2, 4'h8, 0, 0);
        idle(8);
        check_burst("err_a3_r2", '{5, 7, 9, 11, 13, 0}, 0);

        send_err_frame(1, 4'h1, 5, 3);
        send_err_frame(0, 4'h1, 0, 0);
        idle(8);
        check_burst("overlap_second", '{0, 0, 0, 0, 0, 0}, 0);

        for (int k = 0; k < 7; k++) drive_sym(4'($urandom_range(1, 15)));
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_symbol = 4'h5;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        send_err_frame(-1, 4'h0, 0, 0);
        idle(8);
        check_burst("after_rst_frame", '{15, 15, 15, 15, 15, 15}, 1);

        send_err_frame(1, 4'h1, 0, 0);
        idle(3);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        chk("rst_in_send_beats", 32'(obs_n), 32'd3);

        for (int f = 0; f < 25; f++) begin
            send_random_frame();
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 6));
        end
        idle(10);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/syndrome_gen.md
# syndrome_gen

Upstream stage of the GF(2^4) error-location decoder. Accepts a received 15-symbol codeword, one 4-bit symbol per cycle, and evaluates the six syndromes S_j = r(α^j), j = 1..6, by Horner accumulation. Its output stream matches the decoder's `in_valid`/`in_syndrome` input exactly: six consecutive cycles, S1 first, in exponent form. The block is double-buffered, so the next codeword can stream in while the previous syndromes drain.

## Interface
- N_SYM, 15, symbols per codeword (fixed by the field; not meant to be overridden)
- N_SYN, 6, syndromes produced per codeword
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_symbol carries a codeword symbol this cycle
- in_symbol  in  4  received symbol, vector (polynomial) form, bit 0 = α^0 coefficient
- out_valid  out  1  out_syndrome valid; high for exactly N_SYN consecutive cycles per codeword
- out_syndrome  out  4  syndrome in exponent form: k means α^k (k = 0..14); 4'hF means the zero element
- out_clean  out  1  high with S1 only (first out_valid cycle) when all six syndromes are zero

## Operation
- Field: GF(16) with primitive polynomial x^4+x+1 (α^4 = α+1). Example vector forms: α^0=0001, α^1=0010, α^3=1000, α^4=0011.
- Symbol order: the first accepted symbol is r14 (coefficient of x^14), the last is r0.
- Accumulation:
  - Six 4-bit accumulators A1..A6, in vector form.
  - On each accepted symbol, every accumulator updates as Aj ← Aj·α^j ⊕ in_symbol.
  - The multiplications are constant GF multipliers (XOR networks); no multipliers or tables are indexed at runtime.
  - On the first symbol of a frame, the accumulators are treated as 0, i.e. Aj ← in_symbol.
- Symbol counter `cnt` (0..14):
  - Increments on each cycle with in_valid=1.
  - If in_valid drops mid-frame, accumulators and `cnt` hold; the frame resumes when in_valid returns.
  - The frame completes on the 15th accepted symbol; `cnt` then wraps to 0.
- Handoff on frame completion: the final A1..A6 values (including the 15th symbol's update) are converted to exponent form and loaded into a 6-entry output shift register.
  - Conversion uses a 16-entry log ROM; vector 0 maps to 4'hF.
  - The all-zero check is also latched at this point.
- Output FSM, two states:
  - IDLE: out_valid=0, out_syndrome=0, out_clean=0. Moves to SEND on frame completion.
  - SEND: presents entries S1..S6 on successive cycles, using a 3-bit index 0..5. out_clean is driven only at index 0. Returns to IDLE after index 5.
- Overlap: accumulation of frame N+1 proceeds freely during SEND of frame N. The earliest possible completion of frame N+1 is 15 cycles later, so the shift register is never overwritten mid-send. No back-pressure port exists.
- All outputs are registered.

## Timing
- Reset: out_valid=0, out_syndrome=4'h0, out_clean=0, `cnt`=0, accumulators=0, FSM=IDLE.
- Reset has priority over every other event.
- Reset asserted mid-frame or mid-SEND discards all state. Outputs read their reset values in the cycle after the reset edge.
- Latency:
  - The 15th symbol is sampled at edge T.
  - out_valid is high after edges T+1 .. T+6, carrying S1..S6 in order.
  - out_valid is low after edge T+7, unless a new send begins, which cannot happen before T+15.
- When out_valid=0, out_syndrome=0 and out_clean=0 (the decoder bench checks this).
- Back-to-back frames (in_valid high for 30 cycles) produce two 6-cycle bursts exactly 15 cycles apart.
- in_valid asserted on the same cycle as the final SEND beat is legal and accepted.

## Test plan
- All-zero codeword, 15 × 4'h0 → out_syndrome = F,F,F,F,F,F; out_clean=1 on the first beat; out_valid high exactly 6 cycles starting 1 cycle after the last symbol.
- Single error at r0: symbols 14 × 0 then 4'b0001 → exponents 0,0,0,0,0,0; out_clean=0.
- Single error at r1 (14th symbol = 0001, others 0) → 1,2,3,4,5,6. Single error at r14 (first symbol = 0001, others 0) → 14,13,12,11,10,9.
- Error value α^3 (4'b1000) at r2, others 0 → 5,7,9,11,13,0.
- Gapped and overlapping frames:
  - Single-error-at-r1 frame with in_valid dropped for 3 cycles after the 5th symbol → same 1..6 result; the output burst is shifted by 3 cycles.
  - Second frame (single error at r0) started immediately afterwards → its burst 0×6 arrives 15 cycles after the first.
- Reset pulse at the 8th symbol, then a full all-zero frame → no out_valid from the aborted frame; the new frame yields F×6 with out_clean=1.
- Reset during beat 3 of SEND → out_valid=0 from the next cycle, and no remaining beats appear.
